// File: rtl/ls1u_intc_pkg.sv
// Shared definitions for the KC-LS1u+ interrupt controller: register map,
// controller states and the STAT register layout.
package ls1u_intc_pkg;

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_VB0  = 3'd4;
  localparam logic [2:0] OFF_VB1  = 3'd5;
  localparam logic [2:0] OFF_VB2  = 3'd6;
  localparam logic [2:0] OFF_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] zero;
    logic [2:0] idx;
  } stat_t;

  function automatic stat_t make_stat(input logic valid, input logic [2:0] idx);
    stat_t s;
    s.valid = valid;
    s.zero  = 4'b0000;
    s.idx   = idx;
    return s;
  endfunction

endpackage

// File: rtl/ls1u_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module ls1u_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] vec,
  output logic            valid,
  output logic [2:0]      idx
);

  always_comb begin
    valid = |vec;
    idx   = 3'd0;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/ls1u_intc.sv
// Prioritised interrupt controller: latches sources, arbitrates one request at a
// time and follows the core's IN_ISP flag through request, service and return.
module ls1u_intc
  import ls1u_intc_pkg::*;
#(
  parameter int          NSRC      = 8,
  parameter logic [23:0] BASE_ADDR = 24'hFFFF00,
  parameter int          VEC_SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_i,
  input  logic            cpu_wait,
  input  logic            cpu_isp,
  output logic            int_o,
  output logic [23:0]     ivec_o,
  input  logic [23:0]     bus_addr,
  input  logic            bus_we,
  input  logic [7:0]      bus_wdata,
  input  logic            bus_re,
  output logic            bus_sel,
  output logic [7:0]      bus_rdata
);

  state_t          state_reg, state_next;
  logic [NSRC-1:0] irq_d, pend_reg, pend_next, mask_reg, edge_reg;
  logic [23:0]     vbase_reg, ivec_reg, vec_calc;
  logic [2:0]      idx_reg, win_idx;
  logic            win_valid, isp_d, isp_rise, isp_fall;
  logic            ack, capture, hit, wr;
  logic            wr_pend, wr_mask, wr_edge, wr_vb0, wr_vb1, wr_vb2;
  logic [7:0]      pend8, mask8, edge8, rd;

  assign hit     = (bus_addr[23:3] == BASE_ADDR[23:3]);
  assign bus_sel = hit & (bus_re | bus_we);
  assign wr      = bus_sel & bus_we;
  assign wr_pend = wr & (bus_addr[2:0] == OFF_PEND);
  assign wr_mask = wr & (bus_addr[2:0] == OFF_MASK);
  assign wr_edge = wr & (bus_addr[2:0] == OFF_EDGE);
  assign wr_vb0  = wr & (bus_addr[2:0] == OFF_VB0);
  assign wr_vb1  = wr & (bus_addr[2:0] == OFF_VB1);
  assign wr_vb2  = wr & (bus_addr[2:0] == OFF_VB2);

  assign isp_rise = cpu_isp & ~isp_d;
  assign isp_fall = ~cpu_isp & isp_d;

  ls1u_prio_enc #(.NSRC(NSRC)) u_prio (
    .vec   (pend_reg & mask_reg),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign vec_calc = vbase_reg + ({21'd0, win_idx} << VEC_SHIFT);

  // Edge sources: a new rising edge wins over both W1C and the acknowledge clear.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    assign pend_next[gi] = edge_reg[gi]
      ? ((irq_i[gi] & ~irq_d[gi]) |
         (pend_reg[gi] & ~(wr_pend & bus_wdata[gi]) & ~(ack & (idx_reg == 3'(gi)))))
      : irq_i[gi];
  end

  always_comb begin
    state_next = state_reg;
    int_o      = 1'b0;
    ack        = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          capture    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        int_o = ~cpu_wait;
        if (isp_rise) begin
          ack        = 1'b1;
          state_next = ST_SERV;
        end
      end
      ST_SERV: begin
        if (isp_fall) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      irq_d     <= '0;
      isp_d     <= 1'b0;
      pend_reg  <= '0;
      mask_reg  <= '0;
      edge_reg  <= '0;
      vbase_reg <= '0;
      idx_reg   <= '0;
      ivec_reg  <= '0;
    end else begin
      state_reg <= state_next;
      irq_d     <= irq_i;
      isp_d     <= cpu_isp;
      pend_reg  <= pend_next;
      if (capture) begin
        idx_reg  <= win_idx;
        ivec_reg <= vec_calc;
      end
      if (wr_mask) mask_reg <= bus_wdata[NSRC-1:0];
      if (wr_edge) edge_reg <= bus_wdata[NSRC-1:0];
      if (wr_vb0)  vbase_reg[7:0]   <= bus_wdata;
      if (wr_vb1)  vbase_reg[15:8]  <= bus_wdata;
      if (wr_vb2)  vbase_reg[23:16] <= bus_wdata;
    end
  end

  assign ivec_o = ivec_reg;

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    edge8 = '0;
    pend8[NSRC-1:0] = pend_reg;
    mask8[NSRC-1:0] = mask_reg;
    edge8[NSRC-1:0] = edge_reg;
    rd = 8'h00;
    case (bus_addr[2:0])
      OFF_PEND: rd = pend8;
      OFF_MASK: rd = mask8;
      OFF_EDGE: rd = edge8;
      OFF_STAT: rd = make_stat(state_reg != ST_IDLE, idx_reg);
      OFF_VB0:  rd = vbase_reg[7:0];
      OFF_VB1:  rd = vbase_reg[15:8];
      OFF_VB2:  rd = vbase_reg[23:16];
      OFF_RSVD: rd = 8'h00;
      default:  rd = 8'h00;
    endcase
    bus_rdata = hit ? rd : 8'h00;
  end

endmodule

// File: tb/tb_ls1u_intc.sv
// Bench for ls1u_intc: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the controller.
module tb_ls1u_intc;

  localparam logic [23:0] BASE = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_i = '0;
  logic        cpu_wait = 1'b0;
  logic        cpu_isp = 1'b0;
  logic        int_o;
  logic [23:0] ivec_o;
  logic [23:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic        bus_re = 1'b0;
  logic        bus_sel;
  logic [7:0]  bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  ls1u_intc #(.NSRC(8), .BASE_ADDR(BASE), .VEC_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .cpu_wait(cpu_wait), .cpu_isp(cpu_isp),
    .int_o(int_o), .ivec_o(ivec_o), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_re(bus_re), .bus_sel(bus_sel), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]  m_pend, m_mask, m_edge, m_irq_prev;
  bit [23:0] m_vbase, m_vec;
  bit        m_busy, m_acked, m_isp_prev;
  int        m_idx;

  function automatic bit [7:0] model_read(input int off);
    case (off)
      0: return m_pend;
      1: return m_mask;
      2: return m_edge;
      3: return {m_busy, 4'b0000, 3'(m_idx)};
      4: return m_vbase[7:0];
      5: return m_vbase[15:8];
      6: return m_vbase[23:16];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_edge = 0; m_irq_prev = 0; m_vbase = 0; m_vec = 0;
      m_busy = 0; m_acked = 0; m_isp_prev = 0; m_idx = 0;
    end else begin
      bit [7:0] elig, np;
      bit ack, wr, w1c;
      int off;
      elig = m_pend & m_mask;
      ack  = 0;
      wr   = bus_we && (bus_addr[23:3] == BASE[23:3]);
      off  = int'(bus_addr[2:0]);
      if (!m_busy) begin
        if (elig != 0) begin
          int w;
          w = 0;
          for (int i = 7; i >= 0; i--) if (elig[i]) w = i;
          m_busy = 1; m_acked = 0; m_idx = w;
          m_vec = m_vbase + 24'(w * 16);
        end
      end else if (!m_acked) begin
        if (cpu_isp && !m_isp_prev) begin m_acked = 1; ack = 1; end
      end else if (!cpu_isp && m_isp_prev) begin
        m_busy = 0;
      end
      for (int i = 0; i < 8; i++) begin
        w1c = wr && off == 0 && bus_wdata[i];
        if (m_edge[i])
          np[i] = (irq_i[i] && !m_irq_prev[i]) || (m_pend[i] && !w1c && !(ack && m_idx == i));
        else
          np[i] = irq_i[i];
      end
      if (wr) begin
        case (off)
          1: m_mask = bus_wdata;
          2: m_edge = bus_wdata;
          4: m_vbase[7:0]   = bus_wdata;
          5: m_vbase[15:8]  = bus_wdata;
          6: m_vbase[23:16] = bus_wdata;
          default: ;
        endcase
      end
      m_pend = np;
      m_irq_prev = irq_i;
      m_isp_prev = cpu_isp;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit hit;
      hit = (bus_addr[23:3] == BASE[23:3]);
      chk("int_o", {31'd0, int_o}, {31'd0, m_busy && !m_acked && !cpu_wait});
      if (m_busy) chk("ivec_o", {8'd0, ivec_o}, {8'd0, m_vec});
      chk("bus_sel", {31'd0, bus_sel}, {31'd0, hit && (bus_re || bus_we)});
      if (hit) chk("bus_rdata", {24'd0, bus_rdata}, {24'd0, model_read(int'(bus_addr[2:0]))});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [7:0] d);
    bus_addr = BASE + 24'(off); bus_we = 1'b1; bus_wdata = d;
    tick();
    bus_we = 1'b0; bus_addr = 24'h000000;
    $display("[TB] write off %0d = %02h", off, d);
  endtask

  task automatic rd_reg(input string name, input int off, input logic [7:0] exp);
    bus_addr = BASE + 24'(off); bus_re = 1'b1;
    @(negedge clk);
    chk(name, {24'd0, bus_rdata}, {24'd0, exp});
    $display("[TB] read off %0d = %02h (expect %02h)", off, bus_rdata, exp);
    @(posedge clk);
    #1;
    bus_re = 1'b0; bus_addr = 24'h000000;
  endtask

  task automatic now(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    $display("[TB] %s = %0h (expect %0h)", name, act, exp);
  endtask

  initial begin
    #1 chk_en = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    now("rst_int", {31'd0, int_o}, 0);
    now("rst_ivec", {8'd0, ivec_o}, 0);
    for (int o = 0; o < 8; o++) rd_reg("rst_reg", o, 8'h00);

    // Basic edge request, ack, pulse during service, served after return
    wr_reg(1, 8'h05); wr_reg(2, 8'h01);
    wr_reg(4, 8'h00); wr_reg(5, 8'h10); wr_reg(6, 8'h00);
    rd_reg("mask_rb", 1, 8'h05);
    rd_reg("edge_rb", 2, 8'h01);
    irq_i = 8'h01; tick(); irq_i = 8'h00;
    now("a_int_lat1", {31'd0, int_o}, 0);
    tick();
    now("a_int", {31'd0, int_o}, 1);
    now("a_ivec", {8'd0, ivec_o}, 32'h001000);
    rd_reg("a_stat", 3, 8'h80);
    cpu_isp = 1'b1; tick();
    now("a_int_serv", {31'd0, int_o}, 0);
    irq_i = 8'h01; tick(); irq_i = 8'h00;
    rd_reg("a_pend_serv", 0, 8'h01);
    cpu_isp = 1'b0; tick();
    now("a_int_idle", {31'd0, int_o}, 0);
    tick();
    now("a_int_again", {31'd0, int_o}, 1);
    now("a_ivec_again", {8'd0, ivec_o}, 32'h001000);
    cpu_isp = 1'b1; tick(); cpu_isp = 1'b0; tick();

    // Simultaneous sources: idx 0 first, then level idx 2
    irq_i = 8'h05; tick(); irq_i = 8'h04; tick();
    now("b_ivec0", {8'd0, ivec_o}, 32'h001000);
    cpu_isp = 1'b1; tick(); cpu_isp = 1'b0; tick(); tick();
    now("b_int2", {31'd0, int_o}, 1);
    now("b_ivec2", {8'd0, ivec_o}, 32'h001020);
    rd_reg("b_stat2", 3, 8'h82);

    // cpu_wait gating
    cpu_wait = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); now("c_wait_int", {31'd0, int_o}, 0); end
    cpu_wait = 1'b0; #1;
    now("c_wait_rel", {31'd0, int_o}, 1);

    // Level src 2 held across RET re-requests; request frozen when it drops
    cpu_isp = 1'b1; tick(); cpu_isp = 1'b0; tick(); tick();
    now("d_rereq_int", {31'd0, int_o}, 1);
    now("d_rereq_ivec", {8'd0, ivec_o}, 32'h001020);
    irq_i = 8'h00; tick();
    now("d_frozen_int", {31'd0, int_o}, 1);
    now("d_frozen_ivec", {8'd0, ivec_o}, 32'h001020);
    cpu_isp = 1'b1; tick(); cpu_isp = 1'b0; tick(); tick();
    now("d_idle_int", {31'd0, int_o}, 0);

    // W1C in IDLE, and set beating W1C
    wr_reg(1, 8'h04);
    irq_i = 8'h01; tick(); irq_i = 8'h00;
    rd_reg("e_pend_set", 0, 8'h01);
    wr_reg(0, 8'h01);
    rd_reg("e_pend_w1c", 0, 8'h00);
    irq_i = 8'h01; wr_reg(0, 8'h01); irq_i = 8'h00;
    rd_reg("e_set_wins", 0, 8'h01);
    wr_reg(0, 8'h01);
    rd_reg("e_pend_clr", 0, 8'h00);

    // Vector wrap, reserved write, VBASE write during REQ
    wr_reg(4, 8'hF8); wr_reg(5, 8'hFF); wr_reg(6, 8'hFF);
    wr_reg(1, 8'h02); wr_reg(2, 8'h02);
    irq_i = 8'h02; tick(); irq_i = 8'h00; tick();
    now("f_wrap_int", {31'd0, int_o}, 1);
    now("f_wrap_ivec", {8'd0, ivec_o}, 32'h000008);
    wr_reg(7, 8'hFF);
    rd_reg("f_rsvd", 7, 8'h00);
    rd_reg("f_mask_kept", 1, 8'h02);
    wr_reg(4, 8'h00);
    now("f_ivec_frozen", {8'd0, ivec_o}, 32'h000008);
    rd_reg("f_vb0", 4, 8'h00);

    // Reset during service
    cpu_isp = 1'b1; tick();
    rst_n = 1'b0; #1;
    now("g_rst_int", {31'd0, int_o}, 0);
    rd_reg("g_rst_stat", 3, 8'h00);
    rd_reg("g_rst_mask", 1, 8'h00);
    cpu_isp = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); now("g_no_req", {31'd0, int_o}, 0); end

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit saw_int;
      @(posedge clk); #1;
      saw_int = int_o;
      rst_n = ($urandom_range(0, 699) != 0);
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) irq_i[b] = ~irq_i[b];
      cpu_wait = ($urandom_range(0, 3) == 0);
      if (!cpu_isp) begin
        if ($urandom_range(0, 2) == 0 && (saw_int || $urandom_range(0, 19) == 0)) cpu_isp = 1'b1;
      end else if ($urandom_range(0, 4) == 0) begin
        cpu_isp = 1'b0;
      end
      bus_we    = ($urandom_range(0, 7) == 0);
      bus_re    = $urandom_range(0, 1) == 1;
      bus_wdata = 8'($urandom);
      if ($urandom_range(0, 9) == 0) bus_addr = 24'($urandom);
      else bus_addr = BASE + 24'($urandom_range(0, 7));
      if (c % 500 == 0)
        $display("[TB] random cycle %0d: irq=%02h isp=%0b int=%0b", c, irq_i, cpu_isp, saw_int);
    end
    bus_we = 1'b0; bus_re = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
